seg_scan_display: RTL and testbench
===================================

Name: seg_scan_display

Overview:
Parametrised, time-multiplexed seven-segment display driver for the board display path. It replaces the fixed four-decoder, four-bus arrangement with one shared segment bus plus NUM_DIGITS anode enables, scanned digit by digit. It adds a load-strobed shadow register, leading-zero suppression, per-digit blanking and decimal points, and a 16-level brightness control. It sits at the CPU top level and takes packed nibbles from any debug source, such as opcode, register indices, PC or result.

Parameters:
NUM_DIGITS, 4, number of digits scanned; must be at least 2.
SCAN_DIV, 50000, clock cycles per digit slot; must be a multiple of 16 and at least 32.
ACTIVE_LOW, 1, 1 means seg and an are driven active-low (common-anode); 0 means active-high.

Ports:
clock  in  1  system clock.
reset  in  1  reset: asynchronous assertion, active-low.
value  in  4*NUM_DIGITS  packed hex nibbles; digit i is value[4i+3:4i]; digit 0 is rightmost.
load  in  1  on a cycle with load=1, capture value, dp_in and blank_in into the shadow registers.
dp_in  in  NUM_DIGITS  decimal point request per digit.
blank_in  in  NUM_DIGITS  force digit i dark when bit i is 1.
lz_en  in  1  leading-zero suppression enable; sampled live, not shadowed.
bright  in  4  brightness level 0..15; sampled live.
seg  out  8  segment bus {dp,g,f,e,d,c,b,a}; registered.
an  out  NUM_DIGITS  anode enables, one-hot when active; registered.
digit_idx  out  clog2(NUM_DIGITS)  index of the current scan slot, for debug.

Behaviour:
- Reset (reset=0, asynchronous) clears the following:
  - prescaler=0, digit_idx=0.
  - Shadow value, dp and blank registers all 0.
  - seg and an drive all-inactive: all 1s when ACTIVE_LOW=1, all 0s otherwise.
- Reset deasserted mid-scan restarts the scan at slot 0, prescaler 0.
- Prescaler behaviour:
  - Counts 0..SCAN_DIV-1 and wraps.
  - On the wrap cycle, digit_idx increments.
  - digit_idx wraps from NUM_DIGITS-1 to 0.
  - Full frame = NUM_DIGITS*SCAN_DIV cycles.
- Shadow registers:
  - load=1 captures on the next clock edge.
  - load may be held high, which makes the display transparent with one cycle of delay.
  - A load mid-slot takes effect at the next output register update; no glitch suppression is required beyond the blanking rule below.
- Digit content for the current slot, i = digit_idx:
  - Hex decode of shadow nibble i, using standard patterns 0-9 and A,b,C,d,E,F (e.g. 0 -> gfedcba=0111111, 1 -> 0000110, 8 -> 1111111).
  - dp bit = shadow dp[i].
- Digit i is dark (an[i] inactive for the whole slot) when either of these holds:
  - shadow blank[i]=1.
  - lz_en=1, i>0, and shadow nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never suppressed by lz_en.
- Anti-ghosting: in the prescaler==0 cycle of every slot, all anodes are inactive.
- Brightness:
  - STEP = SCAN_DIV/16.
  - The anode for the slot is active when prescaler != 0 and prescaler < (bright+1)*STEP.
  - bright=15 gives the full slot minus the blanking cycle; bright=0 gives STEP-1 active cycles.
- Output timing:
  - seg and an are registered and reflect the slot state with one clock of latency.
  - seg is updated every cycle to the current digit's pattern, even when the anodes are off.
- Polarity: ACTIVE_LOW=1 inverts both seg and an at the output register.
- At most one an bit is active at any time. This is an assertion in the bench.

Test Plan:
- Apply reset=0, then release; NUM_DIGITS=4, SCAN_DIV=32, ACTIVE_LOW=1 -> while reset=0, seg=8'hFF and an=4'hF; after release, digit_idx=0 for 32 cycles, then 1, 2, 3, then wraps to 0 at cycle 128.
- Load value=16'h12AF with bright=15 -> the following slots are observed:
  - slot 0: an=4'b1110, seg=~8'h71 (F).
  - slot 3: an=4'b0111, seg=~8'h06 (1).
  - In each slot the anode is active for cycles 1..31 (latency +1) and all anodes are off in cycle 0 of each slot.
- With lz_en=1, load value=16'h0030 -> digits 3 and 2 stay dark, digit 1 shows 3, digit 0 shows 0. Then load value=16'h0000 -> only digit 0 is lit, showing 0.
- Load blank_in=4'b0100 and dp_in=4'b0001 with value=16'h8888 -> digit 2 never lit, digit 0 seg=~8'hFF (8 with dp), other lit digits seg=~8'h7F.
- With bright=0 and SCAN_DIV=32 (STEP=2) -> exactly 1 active anode cycle per slot. With bright=7 -> 15 active cycles per slot.
- Change value without load, then pulse load for 1 cycle mid-slot -> the display keeps the old digits until the pulse, then shows the new digits from the next output update. Assert reset=0 mid-slot -> outputs go inactive asynchronously and the shadow register reads 0.

Source files
------------

// File: rtl/seg_scan_display.sv
// Time-multiplexed seven-segment driver: one shared segment bus, one-hot anode scan,
// shadowed digit data, leading-zero suppression, per-digit blanking and 16-level dimming.
module seg_scan_display #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [4*NUM_DIGITS-1:0]       value,
  input  logic                          load,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic [NUM_DIGITS-1:0]         blank_in,
  input  logic                          lz_en,
  input  logic [3:0]                    bright,
  output logic [7:0]                    seg,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

  localparam int unsigned PW   = $clog2(SCAN_DIV);
  localparam int unsigned IW   = $clog2(NUM_DIGITS);
  localparam int unsigned STEP = SCAN_DIV / 16;

  localparam logic [7:0]            SegOff = {8{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AnOff  = {NUM_DIGITS{ACTIVE_LOW}};

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] val_q;
  logic [NUM_DIGITS-1:0]   dp_q, blank_q;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic [NUM_DIGITS-1:0]   lz_zero;
  logic                    all_zero;
  logic [3:0]              nib;
  logic [6:0]              hex;
  logic                    dark;
  logic                    lit;
  logic [PW:0]             thresh;

  // Prescaler and slot index.
  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  // lz_zero[i] is set when nibbles i..NUM_DIGITS-1 are all zero.
  always_comb begin
    lz_zero  = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero   = all_zero & (val_q[4*i +: 4] == 4'h0);
      lz_zero[i] = all_zero;
    end
  end

  always_comb begin
    nib = val_q[{idx_q, 2'b00} +: 4];
    case (nib)
      4'h0:    hex = 7'h3F;
      4'h1:    hex = 7'h06;
      4'h2:    hex = 7'h5B;
      4'h3:    hex = 7'h4F;
      4'h4:    hex = 7'h66;
      4'h5:    hex = 7'h6D;
      4'h6:    hex = 7'h7D;
      4'h7:    hex = 7'h07;
      4'h8:    hex = 7'h7F;
      4'h9:    hex = 7'h6F;
      4'hA:    hex = 7'h77;
      4'hB:    hex = 7'h7C;
      4'hC:    hex = 7'h39;
      4'hD:    hex = 7'h5E;
      4'hE:    hex = 7'h79;
      default: hex = 7'h71;
    endcase
  end

  // Cycle 0 of each slot is always dark so the previous digit cannot ghost.
  always_comb begin
    thresh = (PW + 1)'((32'(bright) + 32'd1) * STEP);
    dark   = blank_q[idx_q] | (lz_en & (idx_q != '0) & lz_zero[idx_q]);
    lit    = ~dark & (presc_q != '0) & ({1'b0, presc_q} < thresh);
    an_d   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_d[i] = lit & (idx_q == IW'(i));
    end
    an_d  = an_d ^ AnOff;
    seg_d = {dp_q[idx_q], hex} ^ SegOff;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      val_q   <= '0;
      dp_q    <= '0;
      blank_q <= '0;
      seg_q   <= SegOff;
      an_q    <= AnOff;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      if (load) begin
        val_q   <= value;
        dp_q    <= dp_in;
        blank_q <= blank_in;
      end
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign digit_idx = idx_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: per-cycle scoreboard against a frame-position model, plus
// table-driven per-frame checks of lit-cycle counts and segment patterns.
module tb_seg_scan_display;

  logic        clock;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        lz_en;
  logic [3:0]  bright;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic [1:0]  digit_idx;

  int tests = 0;
  int fails = 0;

  seg_scan_display #(
    .NUM_DIGITS(4),
    .SCAN_DIV  (32),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .value    (value),
    .load     (load),
    .dp_in    (dp_in),
    .blank_in (blank_in),
    .lz_en    (lz_en),
    .bright   (bright),
    .seg      (seg),
    .an       (an),
    .digit_idx(digit_idx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected {an, seg} for the cycle at position t since reset release.
  function automatic logic [11:0] expect_out(input int t, input logic [15:0] v,
                                             input logic [3:0] dp, input logic [3:0] bl,
                                             input logic lz, input logic [3:0] br);
    int         pos;
    int         slot;
    logic [3:0] nb;
    logic [15:0] hi;
    logic       dk;
    logic       on;
    logic [3:0] one;
    pos  = t % 32;
    slot = (t / 32) % 4;
    nb   = v[4*slot +: 4];
    hi   = v >> (4 * slot);
    dk   = bl[slot] || (lz && slot > 0 && hi == 16'h0);
    on   = !dk && pos != 0 && pos < (int'(br) + 1) * 2;
    one  = 4'b0001 << slot;
    return {~(on ? one : 4'b0000), ~{dp[slot], HEX[nb]}};
  endfunction

  // Scoreboard: push expected output at each active edge, pop on the following negedge.
  logic [11:0] sb[$];
  int          m_t;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic [3:0]  m_blank;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_t     <= 0;
      m_val   <= '0;
      m_dp    <= '0;
      m_blank <= '0;
      sb.delete();
    end else begin
      sb.push_back(expect_out(m_t, m_val, m_dp, m_blank, lz_en, bright));
      m_t <= m_t + 1;
      if (load) begin
        m_val   <= value;
        m_dp    <= dp_in;
        m_blank <= blank_in;
      end
    end
  end

  logic [11:0] e;
  always @(negedge clock) begin
    tests++;
    assert ($onehot0(~an)) else begin
      fails++;
      $display("FAIL onehot_an: got an=%b, expected at most one active", an);
    end
    if (reset) begin
      chk("sb_digit_idx", 32'(digit_idx), 32'((m_t / 32) % 4));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_an", 32'(an), 32'(e[11:8]));
        chk("sb_seg", 32'(seg), 32'(e[7:0]));
      end
    end
  end

  typedef struct packed {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic [3:0]      blank;
    logic            lz;
    logic [3:0]      bright;
    logic [3:0][7:0] seg;
    logic [3:0][7:0] on;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl,
                              input logic lz, input logic [3:0] br, input logic [31:0] sg,
                              input logic [31:0] on);
    vec_t r;
    r.value  = v;
    r.dp     = dp;
    r.blank  = bl;
    r.lz     = lz;
    r.bright = br;
    r.seg    = sg;
    r.on     = on;
    return r;
  endfunction

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl,
                         input logic lz, input logic [3:0] br);
    @(posedge clock); #1;
    value = v; dp_in = dp; blank_in = bl; lz_en = lz; bright = br; load = 1'b1;
    @(posedge clock); #1;
    load = 1'b0;
    @(posedge clock); #1;
  endtask

  // One full frame: active-cycle count and last lit segment pattern per digit.
  task automatic measure(output logic [3:0][7:0] sc, output logic [3:0][7:0] cn);
    sc = '0;
    cn = '0;
    repeat (128) begin
      @(negedge clock);
      for (int d = 0; d < 4; d++) begin
        if (!an[d]) begin
          cn[d] = cn[d] + 8'd1;
          sc[d] = seg;
        end
      end
    end
  endtask

  task automatic chk_frame(input string tag, input logic [3:0][7:0] exp_seg,
                           input logic [3:0][7:0] exp_on);
    logic [3:0][7:0] sc;
    logic [3:0][7:0] cn;
    measure(sc, cn);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s_cnt_d%0d", tag, d), 32'(cn[d]), 32'(exp_on[d]));
      if (exp_on[d] != 8'd0) chk($sformatf("%s_seg_d%0d", tag, d), 32'(sc[d]), 32'(exp_seg[d]));
    end
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = mk(16'h12AF, 4'h0, 4'h0, 1'b0, 4'd15, {8'hF9, 8'hA4, 8'h88, 8'h8E},
                 {8'd31, 8'd31, 8'd31, 8'd31});
    vecs[1] = mk(16'h0030, 4'h0, 4'h0, 1'b1, 4'd15, {8'h00, 8'h00, 8'hB0, 8'hC0},
                 {8'd0, 8'd0, 8'd31, 8'd31});
    vecs[2] = mk(16'h0000, 4'h0, 4'h0, 1'b1, 4'd15, {8'h00, 8'h00, 8'h00, 8'hC0},
                 {8'd0, 8'd0, 8'd0, 8'd31});
    vecs[3] = mk(16'h8888, 4'b0001, 4'b0100, 1'b0, 4'd15, {8'h80, 8'h00, 8'h80, 8'h00},
                 {8'd31, 8'd0, 8'd31, 8'd31});
    vecs[4] = mk(16'h12AF, 4'h0, 4'h0, 1'b0, 4'd0, {8'hF9, 8'hA4, 8'h88, 8'h8E},
                 {8'd1, 8'd1, 8'd1, 8'd1});
    vecs[5] = mk(16'h12AF, 4'h0, 4'h0, 1'b0, 4'd7, {8'hF9, 8'hA4, 8'h88, 8'h8E},
                 {8'd15, 8'd15, 8'd15, 8'd15});
    vecs[6] = mk(16'h1000, 4'h0, 4'h0, 1'b1, 4'd15, {8'hF9, 8'hC0, 8'hC0, 8'hC0},
                 {8'd31, 8'd31, 8'd31, 8'd31});

    reset = 1'b0; value = '0; load = 1'b0; dp_in = '0; blank_in = '0; lz_en = 1'b0;
    bright = 4'd15;

    repeat (3) begin
      @(negedge clock);
      chk("rst_seg", 32'(seg), 32'h000000FF);
      chk("rst_an", 32'(an), 32'h0000000F);
      chk("rst_idx", 32'(digit_idx), 32'd0);
    end
    @(negedge clock);
    reset = 1'b1;

    // Scan index after k active edges since release.
    for (int k = 1; k <= 130; k++) begin
      @(posedge clock); #1;
      if (k == 31 || k == 32 || k == 64 || k == 96 || k == 127 || k == 128)
        chk($sformatf("scan_idx_k%0d", k), 32'(digit_idx), 32'((k / 32) % 4));
    end

    for (int i = 0; i < 7; i++) begin
      do_load(vecs[i].value, vecs[i].dp, vecs[i].blank, vecs[i].lz, vecs[i].bright);
      chk_frame($sformatf("v%0d", i), vecs[i].seg, vecs[i].on);
    end

    // Input change without load must not reach the display.
    do_load(16'h12AF, 4'h0, 4'h0, 1'b0, 4'd15);
    value = 16'h5555;
    chk_frame("noload", {8'hF9, 8'hA4, 8'h88, 8'h8E}, {8'd31, 8'd31, 8'd31, 8'd31});

    // Single-cycle load pulse in the middle of a slot.
    repeat (13) @(posedge clock);
    #1 load = 1'b1;
    @(posedge clock); #1;
    load = 1'b0;
    @(posedge clock); #1;
    chk_frame("pulse", {8'h92, 8'h92, 8'h92, 8'h92}, {8'd31, 8'd31, 8'd31, 8'd31});

    // Asynchronous reset between clock edges.
    @(negedge clock);
    #3 reset = 1'b0;
    #1;
    chk("async_seg", 32'(seg), 32'h000000FF);
    chk("async_an", 32'(an), 32'h0000000F);
    chk("async_idx", 32'(digit_idx), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk_frame("post_rst", {8'hC0, 8'hC0, 8'hC0, 8'hC0}, {8'd31, 8'd31, 8'd31, 8'd31});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
